// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - shares one single-port synchronous RAM between fetch and data ports
module unified_mem_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int STARVE_MAX = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ireq,
    input  logic [AW-1:0] iaddr,
    output logic [DW-1:0] irdata,
    output logic          ivalid,
    output logic          istall,
    input  logic          dreq,
    input  logic          dwe,
    input  logic [AW-1:0] daddr,
    input  logic [DW-1:0] dwdata,
    output logic [DW-1:0] drdata,
    output logic          dvalid,
    output logic          dstall,
    output logic [AW-2:0] maddr,
    output logic [DW-1:0] mwdata,
    output logic          men,
    output logic          mwe,
    input  logic [DW-1:0] mrdata,
    output logic          busy
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACCESS  = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    localparam logic       OWN_I = 1'b0;
    localparam logic       OWN_D = 1'b1;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [1:0] state;
    logic       owner;
    logic [3:0] starve_cnt;
    logic       grant_d;
    logic       grant_i;
    logic       unused_addr_lsb;

    // Byte-address bit 0 never reaches the word-addressed RAM.
    assign unused_addr_lsb = iaddr[0] ^ daddr[0];

    // Data wins unless fetch has been passed over STARVE_MAX times in a row.
    always_comb begin
        grant_d = dreq & ~(ireq & (starve_cnt == STARVE_LIM));
        grant_i = ireq & ~grant_d;
    end

    assign ivalid = (state == S_RESP) && (owner == OWN_I);
    assign dvalid = (state == S_RESP) && (owner == OWN_D);
    assign istall = ireq & ~ivalid;
    assign dstall = dreq & ~dvalid;
    assign busy   = (state != S_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            owner      <= OWN_I;
            starve_cnt <= 4'd0;
            maddr      <= '0;
            mwdata     <= '0;
            men        <= 1'b0;
            mwe        <= 1'b0;
            irdata     <= '0;
            drdata     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_d || grant_i) begin
                        state  <= S_ACCESS;
                        owner  <= grant_d ? OWN_D : OWN_I;
                        men    <= 1'b1;
                        mwe    <= grant_d & dwe;
                        maddr  <= grant_d ? daddr[AW-1:1] : iaddr[AW-1:1];
                        mwdata <= grant_d ? dwdata : '0;
                        if (grant_d && ireq)
                            starve_cnt <= (starve_cnt == STARVE_LIM) ? starve_cnt
                                                                      : starve_cnt + 4'd1;
                        else
                            starve_cnt <= 4'd0;
                    end
                end
                S_ACCESS: begin
                    // The registered write enable doubles as the latched dwe.
                    state <= mwe ? S_RESP : S_CAPTURE;
                    men   <= 1'b0;
                    mwe   <= 1'b0;
                end
                S_CAPTURE: begin
                    if (owner == OWN_D)
                        drdata <= mrdata;
                    else
                        irdata <= mrdata;
                    state <= S_RESP;
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - directed self-checking bench for unified_mem_arbiter
module tb_unified_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        ireq;
    logic [15:0] iaddr;
    logic [15:0] irdata;
    logic        ivalid;
    logic        istall;
    logic        dreq;
    logic        dwe;
    logic [15:0] daddr;
    logic [15:0] dwdata;
    logic [15:0] drdata;
    logic        dvalid;
    logic        dstall;
    logic [14:0] maddr;
    logic [15:0] mwdata;
    logic        men;
    logic        mwe;
    logic [15:0] mrdata;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] mem [0:255];

    unified_mem_arbiter #(.AW(16), .DW(16), .STARVE_MAX(3)) dut (
        .clock  (clock),
        .reset  (reset),
        .ireq   (ireq),
        .iaddr  (iaddr),
        .irdata (irdata),
        .ivalid (ivalid),
        .istall (istall),
        .dreq   (dreq),
        .dwe    (dwe),
        .daddr  (daddr),
        .dwdata (dwdata),
        .drdata (drdata),
        .dvalid (dvalid),
        .dstall (dstall),
        .maddr  (maddr),
        .mwdata (mwdata),
        .men    (men),
        .mwe    (mwe),
        .mrdata (mrdata),
        .busy   (busy)
    );

    always #5 clock = ~clock;

    // Synchronous RAM model; known contents are loaded while reset is high.
    always @(posedge clock) begin
        if (reset) begin
            mem[8'h02] <= 16'hA123;
            mem[8'h03] <= 16'h3333;
            mem[8'h10] <= 16'h1357;
            mem[8'h18] <= 16'h2468;
            mem[8'h20] <= 16'h0F0F;
            mem[8'h28] <= 16'hF0F0;
            mrdata     <= 16'h0000;
        end else if (men) begin
            if (mwe)
                mem[maddr[7:0]] <= mwdata;
            else
                mrdata <= mem[maddr[7:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    int          men_cnt;
    int          d_at;
    int          i_at;
    int          g;
    logic [15:0] first_addr;
    logic [15:0] d_data;
    logic [15:0] i_data;
    logic [14:0] order [0:3];
    logic [3:0]  cnt_before;
    logic [3:0]  cnt_after;
    logic        i_seen;

    initial begin
        reset = 1'b1; ireq = 1'b0; iaddr = '0; dreq = 1'b0; dwe = 1'b0;
        daddr = '0; dwdata = '0;
        @(negedge clock); @(negedge clock);
        chk("rst_men", men, 0);
        chk("rst_mwe", mwe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", {ivalid, dvalid}, 0);
        chk("rst_maddr", maddr, 0);
        chk("rst_mwdata", mwdata, 0);
        chk("rst_rdata", {irdata, drdata}, 0);
        chk("rst_starve", dut.starve_cnt, 0);
        reset = 1'b0;

        // Single fetch of word 2
        @(negedge clock);
        ireq = 1'b1; iaddr = 16'h0004;
        #1 chk("f_istall_T", istall, 1);
        @(negedge clock);
        chk("f_men", men, 1);
        chk("f_maddr", maddr, 2);
        chk("f_mwe", mwe, 0);
        chk("f_istall_T1", istall, 1);
        @(negedge clock);
        chk("f_ivalid_T2", ivalid, 0);
        chk("f_istall_T2", istall, 1);
        @(negedge clock);
        chk("f_ivalid", ivalid, 1);
        chk("f_irdata", irdata, 16'hA123);
        chk("f_istall_T3", istall, 0);
        ireq = 1'b0;
        @(negedge clock);
        chk("f_idle", {busy, ivalid}, 0);
        chk("f_hold", irdata, 16'hA123);

        // Store then load of 0x0010
        dreq = 1'b1; dwe = 1'b1; daddr = 16'h0010; dwdata = 16'h5A5A;
        #1 chk("s_dstall", dstall, 1);
        @(negedge clock);
        chk("s_men_mwe", {men, mwe}, 2'b11);
        chk("s_maddr", maddr, 8);
        chk("s_mwdata", mwdata, 16'h5A5A);
        @(negedge clock);
        chk("s_dvalid", dvalid, 1);
        chk("s_dstall_done", dstall, 0);
        chk("s_men_off", men, 0);
        dreq = 1'b0; dwe = 1'b0;
        @(negedge clock);
        chk("s_busy", busy, 0);
        chk("s_memword", mem[8], 16'h5A5A);
        dreq = 1'b1; daddr = 16'h0010;
        @(negedge clock);
        chk("l_mwe", {men, mwe}, 2'b10);
        @(negedge clock);
        chk("l_dvalid_early", dvalid, 0);
        @(negedge clock);
        chk("l_dvalid", dvalid, 1);
        chk("l_drdata", drdata, 16'h5A5A);
        dreq = 1'b0;
        @(negedge clock);

        // Simultaneous requests from reset release
        reset = 1'b1; ireq = 1'b1; iaddr = 16'h0030; dreq = 1'b1; dwe = 1'b0; daddr = 16'h0020;
        @(negedge clock); @(negedge clock);
        chk("sim_rst_men", men, 0);
        reset = 1'b0;
        men_cnt = 0; d_at = -1; i_at = -1; first_addr = 16'hFFFF; d_data = '0; i_data = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            if (men) begin
                men_cnt++;
                if (first_addr == 16'hFFFF) first_addr = {1'b0, maddr};
            end
            if (dvalid) begin d_at = i; d_data = drdata; dreq = 1'b0; end
            if (ivalid) begin i_at = i; i_data = irdata; ireq = 1'b0; end
        end
        chk("sim_first_d", first_addr, 16'h0010);
        chk("sim_men_cnt", men_cnt, 2);
        chk("sim_dvalid_at", d_at, 2);
        chk("sim_ivalid_at", i_at, 6);
        chk("sim_drdata", d_data, 16'h1357);
        chk("sim_irdata", i_data, 16'h2468);
        chk("sim_starve0", dut.starve_cnt, 0);

        // Starvation guard: back-to-back loads with a fetch pending
        ireq = 1'b1; iaddr = 16'h0040; dreq = 1'b1; dwe = 1'b0; daddr = 16'h0050;
        g = 0; i_seen = 1'b0; cnt_before = 4'hF; cnt_after = 4'hF;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (men && g < 4) begin
                order[g] = maddr;
                if (g == 2) cnt_before = dut.starve_cnt;
                if (g == 3) cnt_after = dut.starve_cnt;
                g++;
            end
            if (g == 4 && ivalid && !i_seen) begin
                i_seen = 1'b1; ireq = 1'b0; dreq = 1'b0;
            end
        end
        chk("st_grants", g, 4);
        chk("st_g0_d", order[0], 15'h28);
        chk("st_g1_d", order[1], 15'h28);
        chk("st_g2_d", order[2], 15'h28);
        chk("st_g3_i", order[3], 15'h20);
        chk("st_cnt_sat", cnt_before, 3);
        chk("st_cnt_clr", cnt_after, 0);
        chk("st_ivalid", i_seen, 1);

        // Reset during CAPTURE of an odd-address fetch
        ireq = 1'b1; iaddr = 16'h0007;
        @(negedge clock);
        chk("odd_maddr", maddr, 3);
        chk("odd_men", men, 1);
        @(negedge clock);
        reset = 1'b1; ireq = 1'b0;
        @(negedge clock);
        chk("mr_valid", {ivalid, dvalid}, 0);
        chk("mr_mem", {men, mwe, busy}, 0);
        chk("mr_maddr", maddr, 0);
        chk("mr_mwdata", mwdata, 0);
        chk("mr_rdata", {irdata, drdata}, 0);
        chk("mr_stall", {istall, dstall}, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("mr_no_pulse", {ivalid, dvalid, busy}, 0);
        ireq = 1'b1; iaddr = 16'h0004;
        @(negedge clock);
        chk("mr_new_men", men, 1);
        @(negedge clock);
        @(negedge clock);
        chk("mr_new_ivalid", ivalid, 1);
        chk("mr_new_irdata", irdata, 16'hA123);
        ireq = 1'b0;
        @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
